// File: rtl/nonce_collector.sv
// Result stage after the hashing pipeline: skips fill garbage, flags hashes <= target,
// and queues winning {nonce, hash} pairs. Define NONCE_COLLECTOR_STATS_EN to build hash/drop counters.
module nonce_collector #(
  parameter int NONCE_W     = 64,
  parameter int HASH_W      = 64,
  parameter int DEPTH       = 4,
  parameter int FILL_CYCLES = 330
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [HASH_W-1:0]        target,
  input  logic [HASH_W-1:0]        keccak_hash,
  input  logic [NONCE_W-1:0]       nonce_check,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NONCE_W-1:0]       out_nonce,
  output logic [HASH_W-1:0]        out_hash,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic [47:0]              hash_count,
  output logic [15:0]              drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(FILL_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       fill_q, fill_d;
  logic [NONCE_W-1:0]  last_nonce_q, last_nonce_d;
  logic                last_valid_q, last_valid_d;
  logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [PW-1:0]       cnt, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [NONCE_W-1:0]  out_nonce_q, out_nonce_d;
  logic [HASH_W-1:0]   out_hash_q, out_hash_d;
  logic                hit, full, push, pop;

  logic [NONCE_W-1:0]  mem_nonce [DEPTH];
  logic [HASH_W-1:0]   mem_hash  [DEPTH];

  always_comb begin
    cnt  = wr_q - rd_q;
    full = (cnt == PW'(DEPTH));
    hit  = enable && (state_q == RUN) && (keccak_hash <= target) &&
           (!last_valid_q || (nonce_check != last_nonce_q));
    pop  = out_valid_q && out_ready;
    // A full FIFO still takes the hit when the head leaves in the same cycle.
    push = hit && (!full || pop);
    wr_d = wr_q + PW'(push);
    rd_d = rd_q + PW'(pop);
    cnt_d = wr_d - rd_d;

    state_d = state_q;
    fill_d  = fill_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = FILL;
          fill_d  = CW'(FILL_CYCLES - 1);
        end
        FILL: begin
          if (fill_q == '0) state_d = RUN;
          else              fill_d  = fill_q - 1'b1;
        end
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end

    last_valid_d = last_valid_q;
    last_nonce_d = last_nonce_q;
    if (!enable) begin
      last_valid_d = 1'b0;
    end else if (hit) begin
      last_valid_d = 1'b1;
      last_nonce_d = nonce_check;
    end

    // Head registers track the entry that will sit at rd_d after this edge.
    out_valid_d = (cnt_d != '0);
    out_nonce_d = '0;
    out_hash_d  = '0;
    if (cnt_d != '0) begin
      if (push && (rd_d[AW-1:0] == wr_q[AW-1:0])) begin
        out_nonce_d = nonce_check;
        out_hash_d  = keccak_hash;
      end else begin
        out_nonce_d = mem_nonce[rd_d[AW-1:0]];
        out_hash_d  = mem_hash[rd_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fill_q       <= '0;
      last_nonce_q <= '0;
      last_valid_q <= 1'b0;
      wr_q         <= '0;
      rd_q         <= '0;
      out_valid_q  <= 1'b0;
      out_nonce_q  <= '0;
      out_hash_q   <= '0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      last_nonce_q <= last_nonce_d;
      last_valid_q <= last_valid_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      out_valid_q  <= out_valid_d;
      out_nonce_q  <= out_nonce_d;
      out_hash_q   <= out_hash_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_nonce[wr_q[AW-1:0]] <= nonce_check;
      mem_hash[wr_q[AW-1:0]]  <= keccak_hash;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_nonce  = out_nonce_q;
  assign out_hash   = out_hash_q;
  assign fifo_count = cnt;
  assign busy       = (state_q != IDLE);

`ifdef NONCE_COLLECTOR_STATS_EN
  logic [47:0] hash_cnt_q, hash_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    hash_cnt_d = hash_cnt_q + 48'(enable && (state_q == RUN));
    drop_cnt_d = drop_cnt_q;
    if (hit && full && !pop && (drop_cnt_q != 16'hFFFF))
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hash_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      hash_cnt_q <= hash_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign hash_count = hash_cnt_q;
  assign drop_count = drop_cnt_q;
`else
  assign hash_count = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_nonce_collector.sv
// Directed bench for nonce_collector: vector table for fill/single-hit, hand sequences for multi-cycle corners.
module tb_nonce_collector;

`ifdef NONCE_COLLECTOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] TGT  = 64'h0000_0100_0000_0000;
  localparam logic [63:0] HHIT = 64'h0000_00FF_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [63:0] target = '0;
  logic [63:0] keccak_hash = '0;
  logic [63:0] nonce_check = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_nonce;
  logic [63:0] out_hash;
  logic [2:0]  fifo_count;
  logic        busy;
  logic [47:0] hash_count;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  nonce_collector #(.NONCE_W(64), .HASH_W(64), .DEPTH(4), .FILL_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .target(target),
    .keccak_hash(keccak_hash), .nonce_check(nonce_check),
    .out_valid(out_valid), .out_ready(out_ready), .out_nonce(out_nonce),
    .out_hash(out_hash), .fifo_count(fifo_count), .busy(busy),
    .hash_count(hash_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        rdy;
    logic [63:0] tgt;
    logic [63:0] hash;
    logic [63:0] nonce;
    logic        xv;
    logic [63:0] xn;
    logic [63:0] xh;
    logic [63:0] xc;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, " out_nonce"}, out_nonce, 64'd0);
    chk({tag, " out_hash"}, out_hash, 64'd0);
    chk({tag, " fifo_count"}, {61'd0, fifo_count}, 64'd0);
    chk({tag, " busy"}, {63'd0, busy}, 64'd0);
    chk({tag, " hash_count"}, {16'd0, hash_count}, 64'd0);
    chk({tag, " drop_count"}, {48'd0, drop_count}, 64'd0);
  endtask

  task automatic do_reset();
    enable = 1'b0; out_ready = 1'b0; keccak_hash = ONES; nonce_check = '0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // Leaves the DUT in RUN; the next step() is the first evaluated edge.
  task automatic start_run();
    target = TGT; keccak_hash = ONES; enable = 1'b1;
    for (int i = 0; i < 5; i++) step();
  endtask

  initial begin
    for (int k = 0; k < 5; k++)
      tbl[k] = '{1'b1, 1'b0, ONES, 64'd0, 64'h100 + 64'(k), 1'b0, 64'd0, 64'd0, 64'd0};
    tbl[5]  = '{1'b1, 1'b0, ONES, 64'd0, 64'h105, 1'b1, 64'h105, 64'd0, 64'd1};
    tbl[6]  = '{1'b1, 1'b0, ONES, 64'd0, 64'h106, 1'b1, 64'h105, 64'd0, 64'd2};
    tbl[7]  = '{1'b0, 1'b1, ONES, 64'd0, 64'h107, 1'b1, 64'h106, 64'd0, 64'd1};
    tbl[8]  = '{1'b0, 1'b1, ONES, 64'd0, 64'h108, 1'b0, 64'd0, 64'd0, 64'd0};
    tbl[9]  = '{1'b1, 1'b0, TGT, ONES, 64'h109, 1'b0, 64'd0, 64'd0, 64'd0};
    tbl[10] = '{1'b1, 1'b0, TGT, ONES, 64'h10a, 1'b0, 64'd0, 64'd0, 64'd0};
    tbl[11] = '{1'b1, 1'b0, TGT, ONES, 64'h10b, 1'b0, 64'd0, 64'd0, 64'd0};
    tbl[12] = '{1'b1, 1'b0, TGT, 64'd0, 64'h77, 1'b0, 64'd0, 64'd0, 64'd0};
    tbl[13] = '{1'b1, 1'b0, TGT, ONES, 64'h10d, 1'b0, 64'd0, 64'd0, 64'd0};
    tbl[14] = '{1'b1, 1'b0, TGT, HHIT, 64'h2a, 1'b1, 64'h2a, HHIT, 64'd1};
    tbl[15] = '{1'b1, 1'b1, TGT, ONES, 64'h10f, 1'b0, 64'd0, 64'd0, 64'd0};
    tbl[16] = '{1'b1, 1'b1, TGT, ONES, 64'h110, 1'b0, 64'd0, 64'd0, 64'd0};

    // Reset state
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill window, enable drop, then single hit and drain
    for (int i = 0; i < 17; i++) begin
      enable = tbl[i].en; out_ready = tbl[i].rdy; target = tbl[i].tgt;
      keccak_hash = tbl[i].hash; nonce_check = tbl[i].nonce;
      step();
      chk($sformatf("vec%0d out_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].xv});
      chk($sformatf("vec%0d out_nonce", i), out_nonce, tbl[i].xn);
      chk($sformatf("vec%0d out_hash", i), out_hash, tbl[i].xh);
      chk($sformatf("vec%0d fifo_count", i), {61'd0, fifo_count}, tbl[i].xc);
    end

    // Duplicate nonce held for 10 cycles
    do_reset();
    start_run();
    keccak_hash = 64'h10; nonce_check = 64'h55;
    for (int i = 0; i < 10; i++) step();
    chk("dup fifo_count", {61'd0, fifo_count}, 64'd1);
    chk("dup out_nonce", out_nonce, 64'h55);
    chk("dup out_valid", {63'd0, out_valid}, 64'd1);

    // Overflow with 6 distinct hits, then push+pop on full, then drain order
    do_reset();
    start_run();
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      nonce_check = 64'(k); keccak_hash = 64'h20 + 64'(k);
      step();
    end
    chk("ovf fifo_count", {61'd0, fifo_count}, 64'd4);
    chk("ovf head nonce", out_nonce, 64'd1);
    chk("ovf head hash", out_hash, 64'h21);
    chk("ovf drop_count", {48'd0, drop_count}, STATS ? 64'd2 : 64'd0);
    chk("ovf hash_count", {16'd0, hash_count}, STATS ? 64'd6 : 64'd0);
    out_ready = 1'b1; nonce_check = 64'h99; keccak_hash = 64'h99;
    step();
    chk("fullpp fifo_count", {61'd0, fifo_count}, 64'd4);
    chk("fullpp drop_count", {48'd0, drop_count}, STATS ? 64'd2 : 64'd0);
    chk("fullpp head nonce", out_nonce, 64'd2);
    keccak_hash = ONES;
    step();
    chk("drain1 nonce", out_nonce, 64'd3);
    step();
    chk("drain2 nonce", out_nonce, 64'd4);
    step();
    chk("drain3 nonce", out_nonce, 64'h99);
    chk("drain3 hash", out_hash, 64'h99);
    step();
    chk("drain4 valid", {63'd0, out_valid}, 64'd0);
    chk("drain4 nonce", out_nonce, 64'd0);
    chk("drain4 count", {61'd0, fifo_count}, 64'd0);

    // Async reset mid-run with 3 entries, then restart
    do_reset();
    start_run();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nonce_check = 64'ha1 + 64'(k); keccak_hash = 64'h5;
      step();
    end
    chk("pre-rst fifo_count", {61'd0, fifo_count}, 64'd3);
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("async rst");
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      nonce_check = 64'hb0 + 64'(k);
      step();
      if (k == 0) begin
        chk("restart busy", {63'd0, busy}, 64'd1);
        chk("restart valid", {63'd0, out_valid}, 64'd0);
      end
      if (k == 4) chk("restart fill count", {61'd0, fifo_count}, 64'd0);
    end
    chk("restart count", {61'd0, fifo_count}, 64'd1);
    chk("restart nonce", out_nonce, 64'hb5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nonce_collector.md
# nonce_collector

Result stage downstream of the Skein/Keccak hashing connector. Samples the per-cycle `{keccak_hash, nonce_check}` stream, discards the pipeline-fill garbage, compares each hash against a programmable target, and buffers winning nonces in a small FIFO behind a valid/ready handshake toward the host/share-submission logic.

## Interface

- `NONCE_W`, 64, width of nonce_check / out_nonce
- `HASH_W`, 64, width of keccak_hash / target / out_hash
- `DEPTH`, 4, FIFO entries (power of two, ≥2)
- `FILL_CYCLES`, 330, cycles ignored after run start (covers the hashing pipeline plus the nonce delay line)
- `clk  in  1  rising-edge clock`
- `rst  in  1  reset; asynchronous, active-high`
- `enable  in  1  level; 1 = mining run active`
- `target  in  HASH_W  hit when keccak_hash <= target (unsigned)`
- `keccak_hash  in  HASH_W  hash from upstream, one per cycle`
- `nonce_check  in  NONCE_W  nonce aligned with keccak_hash`
- `out_valid  out  1  FIFO head valid`
- `out_ready  in  1  consumer accepts head`
- `out_nonce  out  NONCE_W  head nonce`
- `out_hash  out  HASH_W  head hash`
- `fifo_count  out  $clog2(DEPTH)+1  occupancy`
- `busy  out  1  state != IDLE`
- `hash_count  out  48  hashes evaluated in RUN (stats only)`
- `drop_count  out  16  hits lost to full FIFO (stats only)`

## Operation

- FSM states: IDLE, FILL, RUN.
  - IDLE → FILL when enable=1; fill counter loads FILL_CYCLES-1.
  - FILL: counter decrements each cycle; → RUN the cycle after it reaches 0 (exactly FILL_CYCLES cycles in FILL). Inputs ignored.
  - RUN: each cycle evaluates hit = (keccak_hash <= target) && (nonce_check != last_nonce || !last_valid).
  - Any state → IDLE when enable=0 (takes priority). FIFO contents retained; last_valid cleared.
- Duplicate suppression: last_nonce/last_valid register the nonce of the most recent accepted hit; an identical nonce in consecutive or later cycles is not re-pushed while last_valid=1.
- FIFO: circular, DEPTH entries of {nonce, hash}, pointers one bit wider than index, wrap naturally.
  - push = hit; pop = out_valid && out_ready.
  - Full and push without pop: hit dropped, drop_count += 1 (saturating at 0xFFFF); last_nonce still updated.
  - Full with simultaneous pop: push accepted, count unchanged.
  - Empty with simultaneous push: out_valid rises next cycle; no bypass.
- out_nonce/out_hash are the head entry registers; undefined-but-stable content is not allowed — when empty they hold 0.
- hash_count increments once per RUN cycle, wraps at 2^48.
- Reset: state=IDLE, FIFO empty, out_valid=0, out_nonce=0, out_hash=0, fifo_count=0, busy=0, hash_count=0, drop_count=0, last_valid=0.

## Timing

- Hit latency: inputs sampled at edge N in RUN → entry visible (out_valid=1) after edge N, i.e. cycle N+1, if FIFO was empty.
- First evaluated sample: FILL_CYCLES+1 edges after the edge that sees enable=1.
- Pop at edge M → next head (or out_valid=0) visible cycle M+1.
- enable falling at edge K: no push from sample at edge K.
- rst assertion mid-run clears everything immediately, independent of clk.
- Throughput: one evaluation and one pop per cycle.

## Configuration

- `NONCE_COLLECTOR_STATS_EN` defined: hash_count and drop_count counters built as described.
- Undefined: counter logic removed; hash_count and drop_count tied to 0; dropping on full still occurs.

## Test plan

- Reset/fill: FILL_CYCLES=4, enable=1, target=all-ones → out_valid=0 for first 5 cycles after enable, first entry carries nonce present at edge 5.
- Single hit: target=0x0000_0100_0000_0000, one cycle hash=0x0000_00FF_0000_0000 nonce=0x2A, others hash=all-ones → exactly one entry {0x2A, 0x0000_00FF_0000_0000}, out_ready=1 drains it next cycle.
- Duplicate: nonce held at 0x55 with hitting hash for 10 cycles → fifo_count=1, one entry 0x55.
- Overflow: DEPTH=4, out_ready=0, 6 distinct hits → fifo_count=4, entries are first 4 nonces in order, drop_count=2 (stats on) / 0 (stats off).
- Full push+pop: FIFO full, out_ready=1 and hit nonce 0x99 same cycle → fifo_count stays 4, drop_count unchanged, 0x99 at tail.
- Async reset mid-RUN with 3 entries queued → all outputs 0 without a clock edge; enable then restarts FILL.
